// File: rtl/spi_pkg.sv
// Shared SPI definitions for the LCD link (master and slave sides).
package spi_pkg;

  // Default transfer width, MSB first on the wire
  localparam int SPI_DATA_W = 8;

  // Mode 0: SCLK idles low, data sampled on the rising edge
  localparam bit CPOL = 1'b0;
  localparam bit CPHA = 1'b0;

  // Slave receiver states: IDLE while SS is high, SHIFT while SS is low
  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_e;

endpackage

// File: rtl/sync_ff.sv
// Single-bit flop chain that brings an asynchronous pin into the clk domain.
module sync_ff #(
  parameter int   STAGES    = 2,
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic q_o
);

  logic [STAGES-1:0] chain_q;

  // Shift the pin value down the chain; reset loads the pin's idle level
  always_ff @(posedge clk) begin
    if (!rst) chain_q <= {STAGES{RESET_VAL}};
    else      chain_q <= {chain_q[STAGES-2:0], d_i};
  end

  assign q_o = chain_q[STAGES-1];

endmodule

// File: rtl/spi_slave_rx.sv
// SPI mode-0 slave receiver. All SPI pins are oversampled on clk; received
// bytes go out through a one-entry valid/ready holding register and a status
// byte is returned on MISO.
module spi_slave_rx
  import spi_pkg::*;
#(
  parameter int DATA_W      = SPI_DATA_W,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              SCLK,
  input  logic              SS,
  input  logic              MOSI,
  input  logic              DC,
  output logic              MISO,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_dc,
  output logic              rx_valid,
  input  logic              rx_ready,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              clear_err,
  output logic              overrun,
  output logic              frame_err,
  output logic              busy
);

  localparam int CNT_W = $clog2(DATA_W + 1);

  logic sclkS, ssS, mosiS, dcS;

  sync_ff #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) uSyncSclk (.clk(clk), .rst(rst), .d_i(SCLK), .q_o(sclkS));
  sync_ff #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) uSyncSs   (.clk(clk), .rst(rst), .d_i(SS),   .q_o(ssS));
  sync_ff #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) uSyncMosi (.clk(clk), .rst(rst), .d_i(MOSI), .q_o(mosiS));
  sync_ff #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) uSyncDc   (.clk(clk), .rst(rst), .d_i(DC),   .q_o(dcS));

  logic sclkPrev_q, ssPrev_q;
  logic sclkRise_q, sclkFall_q, ssRise_q, ssFall_q;
  logic mosiE_q, dcE_q;

  // Edge-detect stage: registered edge pulses with MOSI/DC delayed to stay aligned
  always_ff @(posedge clk) begin
    if (!rst) begin
      sclkPrev_q <= 1'b0;
      ssPrev_q   <= 1'b1;
      sclkRise_q <= 1'b0;
      sclkFall_q <= 1'b0;
      ssRise_q   <= 1'b0;
      ssFall_q   <= 1'b0;
      mosiE_q    <= 1'b0;
      dcE_q      <= 1'b0;
    end else begin
      sclkPrev_q <= sclkS;
      ssPrev_q   <= ssS;
      sclkRise_q <= sclkS & ~sclkPrev_q;
      sclkFall_q <= ~sclkS & sclkPrev_q;
      ssRise_q   <= ssS & ~ssPrev_q;
      ssFall_q   <= ~ssS & ssPrev_q;
      mosiE_q    <= mosiS;
      dcE_q      <= dcS;
    end
  end

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   bitCnt_q, bitCnt_d;
  logic [DATA_W-1:0]  rxShift_q, rxShift_d;
  logic [DATA_W-1:0]  txShift_q, txShift_d;
  logic               miso_q, miso_d;
  logic [DATA_W-1:0]  rxData_q, rxData_d;
  logic               rxDc_q, rxDc_d;
  logic               rxValid_q, rxValid_d;
  logic               overrun_q, overrun_d;
  logic               frameErr_q, frameErr_d;
  logic               accept, overrunEvt, frameEvt;

  // Next-state logic: FSM, shift registers, holding register and sticky flags
  always_comb begin
    state_d    = state_q;
    bitCnt_d   = bitCnt_q;
    rxShift_d  = rxShift_q;
    txShift_d  = txShift_q;
    miso_d     = miso_q;
    rxData_d   = rxData_q;
    rxDc_d     = rxDc_q;
    rxValid_d  = rxValid_q;
    overrunEvt = 1'b0;
    frameEvt   = 1'b0;
    accept     = rxValid_q & rx_ready;

    if (accept) rxValid_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        miso_d = 1'b0;
        if (ssFall_q) begin
          state_d   = ST_SHIFT;
          bitCnt_d  = '0;
          txShift_d = tx_data;
          miso_d    = tx_data[DATA_W-1];
        end
      end
      ST_SHIFT: begin
        if (ssRise_q) begin
          state_d   = ST_IDLE;
          miso_d    = 1'b0;
          frameEvt  = (bitCnt_q != '0);
          bitCnt_d  = '0;
          rxShift_d = '0;
        end else if (sclkRise_q) begin
          rxShift_d = {rxShift_q[DATA_W-2:0], mosiE_q};
          if (bitCnt_q == CNT_W'(DATA_W - 1)) begin
            bitCnt_d  = '0;
            txShift_d = tx_data;
            miso_d    = tx_data[DATA_W-1];
            if (!rxValid_q || accept) begin
              rxData_d  = {rxShift_q[DATA_W-2:0], mosiE_q};
              rxDc_d    = dcE_q;
              rxValid_d = 1'b1;
            end else begin
              overrunEvt = 1'b1;
            end
          end else begin
            bitCnt_d = bitCnt_q + CNT_W'(1);
          end
        end else if (sclkFall_q && bitCnt_q != '0) begin
          txShift_d = txShift_q << 1;
          miso_d    = txShift_q[DATA_W-2];
        end
      end
      default: state_d = ST_IDLE;
    endcase

    overrun_d  = overrunEvt | (overrun_q & ~clear_err);
    frameErr_d = frameEvt   | (frameErr_q & ~clear_err);
  end

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      bitCnt_q   <= '0;
      rxShift_q  <= '0;
      txShift_q  <= '0;
      miso_q     <= 1'b0;
      rxData_q   <= '0;
      rxDc_q     <= 1'b0;
      rxValid_q  <= 1'b0;
      overrun_q  <= 1'b0;
      frameErr_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      bitCnt_q   <= bitCnt_d;
      rxShift_q  <= rxShift_d;
      txShift_q  <= txShift_d;
      miso_q     <= miso_d;
      rxData_q   <= rxData_d;
      rxDc_q     <= rxDc_d;
      rxValid_q  <= rxValid_d;
      overrun_q  <= overrun_d;
      frameErr_q <= frameErr_d;
    end
  end

  assign MISO      = miso_q;
  assign rx_data   = rxData_q;
  assign rx_dc     = rxDc_q;
  assign rx_valid  = rxValid_q;
  assign overrun   = overrun_q;
  assign frame_err = frameErr_q;
  assign busy      = (state_q == ST_SHIFT);

endmodule

// File: tb/tb_spi_slave_rx.sv
// Self-checking bench for spi_slave_rx: directed scenarios plus random frames
// compared against a byte-level model of the holding register and flags.
module tb_spi_slave_rx;

  localparam int HALF  = 12;
  localparam int SETUP = 10;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       SCLK = 1'b0, SS = 1'b1, MOSI = 1'b0, DC = 1'b0;
  logic       MISO;
  logic [7:0] rx_data;
  logic       rx_dc, rx_valid;
  logic       rx_ready = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       clear_err = 1'b0;
  logic       overrun, frame_err, busy;

  spi_slave_rx #(.DATA_W(8), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst(rst), .SCLK(SCLK), .SS(SS), .MOSI(MOSI), .DC(DC),
    .MISO(MISO), .rx_data(rx_data), .rx_dc(rx_dc), .rx_valid(rx_valid),
    .rx_ready(rx_ready), .tx_data(tx_data), .clear_err(clear_err),
    .overrun(overrun), .frame_err(frame_err), .busy(busy)
  );

  // Free-running system clock
  always #5 clk = ~clk;

  int checkCount = 0;
  int failCount  = 0;
  int validCycles = 0;

  logic [8:0] expQ[$];
  logic [8:0] gotQ[$];

  bit         mHeld = 0;
  logic [7:0] mData = 0;
  bit         mDc = 0, mOverrun = 0, mFrameErr = 0;

  logic [7:0] fMosi[4], fMiso[4], fGot[4];
  bit         fDc[4];

  // Consumer monitor: record every handshake, count cycles with rx_valid high
  always @(negedge clk) begin
    if (rst && rx_valid && rx_ready) gotQ.push_back({rx_dc, rx_data});
    if (rx_valid) validCycles++;
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checkCount++;
    if (got !== exp) begin
      failCount++;
      $display("[TB] FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic modelComplete(input logic [7:0] b, input bit dcv, input int mode);
    bit acc;
    if (mode == 2) begin mOverrun = 0; mFrameErr = 0; end
    acc = (mode == 1) || rx_ready;
    if (mHeld && !acc) begin
      mOverrun = 1;
    end else begin
      if (mHeld) expQ.push_back({mDc, mData});
      mData = b;
      mDc   = dcv;
      if (rx_ready) begin expQ.push_back({dcv, b}); mHeld = 0; end
      else mHeld = 1;
    end
  endtask

  task automatic modelReset();
    mHeld = 0; mData = 0; mDc = 0; mOverrun = 0; mFrameErr = 0;
    expQ.delete(); gotQ.delete();
  endtask

  task automatic setReady(input bit v);
    rx_ready = v;
    if (v && mHeld) begin expQ.push_back({mDc, mData}); mHeld = 0; end
    tick(3);
  endtask

  task automatic pulseClear();
    clear_err = 1'b1;
    tick(1);
    clear_err = 1'b0;
    tick(1);
    mOverrun = 0; mFrameErr = 0;
  endtask

  // One SPI bit as a mode-0 master; mode selects an action at the cycle the
  // final rise completes the byte (1: accept, 2: clear_err, 3: latency probe)
  task automatic spiBit(input bit b, input bit dcv, input int mode, input bit last, output bit mb);
    MOSI = b; DC = dcv;
    tick(HALF);
    mb = MISO;
    SCLK = 1'b1;
    if (last && mode != 0) begin
      tick(3);
      if (mode == 1) rx_ready = 1'b1;
      if (mode == 2) clear_err = 1'b1;
      if (mode == 3) checkOutput("lat_before", rx_valid, 0);
      tick(1);
      if (mode == 1) rx_ready = 1'b0;
      if (mode == 2) clear_err = 1'b0;
      if (mode == 3) checkOutput("lat_at", rx_valid, 1);
      tick(HALF - 4);
    end else begin
      tick(HALF);
    end
    SCLK = 1'b0;
  endtask

  // One SS frame: nBytes full bytes from fMosi/fDc, then partialBits extra bits
  task automatic applyStimulus(input int nBytes, input int partialBits, input int lastMode);
    bit mb;
    tx_data = fMiso[0];
    SS = 1'b0;
    tick(SETUP);
    checkOutput("busy_hi", busy, 1);
    for (int i = 0; i < nBytes; i++) begin
      tx_data = (i + 1 < nBytes) ? fMiso[i+1] : 8'($urandom);
      fGot[i] = 8'h00;
      for (int k = 7; k >= 0; k--) begin
        spiBit(fMosi[i][k], fDc[i], (i == nBytes - 1) ? lastMode : 0, k == 0, mb);
        fGot[i] = {fGot[i][6:0], mb};
      end
      modelComplete(fMosi[i], fDc[i], (i == nBytes - 1) ? lastMode : 0);
    end
    for (int k = 0; k < partialBits; k++) spiBit(1'($urandom), 1'b0, 0, 1'b0, mb);
    if (partialBits > 0) mFrameErr = 1;
    tick(HALF);
    SS = 1'b1;
    tick(SETUP);
    checkOutput("miso_idle", MISO, 0);
    for (int i = 0; i < nBytes; i++) checkOutput("miso_byte", fGot[i], fMiso[i]);
  endtask

  task automatic checkFrame();
    int n;
    checkOutput("acc_count", gotQ.size(), expQ.size());
    n = (gotQ.size() < expQ.size()) ? gotQ.size() : expQ.size();
    for (int i = 0; i < n; i++) checkOutput("acc_byte", gotQ[i], expQ[i]);
    gotQ.delete(); expQ.delete();
    checkOutput("rx_valid", rx_valid, mHeld);
    checkOutput("rx_data", rx_data, mData);
    checkOutput("rx_dc", rx_dc, mDc);
    checkOutput("overrun", overrun, mOverrun);
    checkOutput("frame_err", frame_err, mFrameErr);
    checkOutput("busy_lo", busy, 0);
  endtask

  task automatic checkResetOutputs(input string pfx);
    checkOutput({pfx, "_miso"}, MISO, 0);
    checkOutput({pfx, "_rx_data"}, rx_data, 0);
    checkOutput({pfx, "_rx_dc"}, rx_dc, 0);
    checkOutput({pfx, "_rx_valid"}, rx_valid, 0);
    checkOutput({pfx, "_overrun"}, overrun, 0);
    checkOutput({pfx, "_frame_err"}, frame_err, 0);
    checkOutput({pfx, "_busy"}, busy, 0);
  endtask

  // Watchdog so the run always ends
  initial begin
    #2000000;
    failCount++;
    $display("[TB] FAIL watchdog got=timeout expected=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
    $fatal(1, "[TB] watchdog expired");
  end

  // Main sequence
  initial begin
    bit mb;
    tick(5);
    rst = 1'b1;
    tick(5);
    checkResetOutputs("reset");

    // Single byte with latency probe
    setReady(1);
    validCycles = 0;
    fMosi[0] = 8'hA5; fDc[0] = 1; fMiso[0] = 8'($urandom);
    applyStimulus(1, 0, 3);
    checkOutput("valid_pulse", validCycles, 1);
    checkFrame();

    // MISO return
    fMosi[0] = 8'h00; fDc[0] = 0; fMiso[0] = 8'h3C;
    applyStimulus(1, 0, 0);
    checkFrame();

    // Burst under backpressure
    setReady(0);
    fMosi[0] = 8'h11; fMosi[1] = 8'h22; fMosi[2] = 8'h33;
    fDc[0] = 0; fDc[1] = 1; fDc[2] = 0;
    fMiso[0] = 8'h81; fMiso[1] = 8'h42; fMiso[2] = 8'hE7;
    applyStimulus(3, 0, 0);
    checkFrame();
    setReady(1);
    checkOutput("valid_drop", rx_valid, 0);
    fMosi[0] = 8'h44; fDc[0] = 1; fMiso[0] = 8'h99;
    applyStimulus(1, 0, 0);
    checkFrame();
    pulseClear();

    // Frame error with a byte held
    setReady(0);
    fMosi[0] = 8'h77; fDc[0] = 0; fMiso[0] = 8'h10;
    applyStimulus(1, 0, 0);
    checkFrame();
    applyStimulus(0, 5, 0);
    checkFrame();
    setReady(1);
    fMosi[0] = 8'h5A; fDc[0] = 1; fMiso[0] = 8'hA0;
    applyStimulus(1, 0, 0);
    checkFrame();
    pulseClear();
    checkFrame();

    // Accept in the cycle the next byte completes, then clear vs overrun
    setReady(0);
    fMosi[0] = 8'hD1; fMosi[1] = 8'h2E; fDc[0] = 1; fDc[1] = 0;
    fMiso[0] = 8'h0F; fMiso[1] = 8'hF0;
    applyStimulus(2, 0, 1);
    checkFrame();
    fMosi[0] = 8'h6B; fDc[0] = 1; fMiso[0] = 8'h55;
    applyStimulus(1, 0, 2);
    checkFrame();
    setReady(1);
    pulseClear();

    // Reset mid-frame
    SS = 1'b0;
    tick(SETUP);
    for (int k = 0; k < 4; k++) spiBit(1'b1, 1'b0, 0, 1'b0, mb);
    rst = 1'b0;
    tick(3);
    SS = 1'b1; MOSI = 1'b0; DC = 1'b0; SCLK = 1'b0;
    tick(3);
    rst = 1'b1;
    tick(8);
    modelReset();
    checkResetOutputs("midrst");
    fMosi[0] = 8'hC3; fDc[0] = 0; fMiso[0] = 8'h3A;
    applyStimulus(1, 0, 0);
    checkFrame();

    // Random frames
    for (int f = 0; f < 25; f++) begin
      int nb, pb;
      setReady(1'($urandom));
      if ($urandom_range(3) == 0) pulseClear();
      nb = $urandom_range(1, 3);
      pb = ($urandom_range(3) == 0) ? $urandom_range(1, 7) : 0;
      for (int i = 0; i < 4; i++) begin
        fMosi[i] = 8'($urandom);
        fMiso[i] = 8'($urandom);
        fDc[i]   = 1'($urandom);
      end
      applyStimulus(nb, pb, 0);
      checkFrame();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
    $finish;
  end

endmodule
